rx_drive_serial: RTL

//  Synthesizable drive-side endpoint of the 1801VP1-033 FDC serial link (nSHIFT/nOUT/nDI/nDO/

---
 rtl/rx_drive_serial.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rx_drive_serial.sv
// rtl/rx_drive_serial.sv - drive-side responder for the FDC serial command/transfer link
module rx_drive_serial #(
  parameter int BUF_LEN  = 128,
  parameter int XFER_LEN = 1
) (
  input  logic       PIN_CLK,
  input  logic       PIN_nRST,
  output logic       PIN_nSHIFT,
  output logic       PIN_nOUT,
  output logic       PIN_nDI,
  input  logic       PIN_nDO,
  input  logic       PIN_nRUN,
  input  logic       PIN_nSET,
  output logic       PIN_nERR,
  output logic       PIN_nDONE,
  output logic       PIN_nTR,
  output logic [8:0] CMD_LAST
);

  localparam int PW = $clog2(BUF_LEN);
  // Byte count compared one bit wider than the pointer so XFER_LEN == BUF_LEN is representable.
  localparam logic [PW:0] XFER_W = (PW+1)'(XFER_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_DEC, S_FWAIT, S_FSHIFT, S_ESHIFT, S_EWAIT
  } state_t;

  state_t        state_q, state_d;
  logic [8:0]    cmd_q, cmd_d;
  logic [8:0]    cmd_last_q, cmd_last_d;
  logic [7:0]    dat_q, dat_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          phase_q, phase_d;
  logic          nshift_q, nshift_d;
  logic          nout_q, nout_d;
  logic          ndi_q, ndi_d;
  logic          nerr_q, nerr_d;
  logic          ndone_q, ndone_d;
  logic          ntr_q, ntr_d;

  logic [7:0]    mem_q [BUF_LEN];
  logic          mem_we;
  logic [PW-1:0] ptr_inc;
  logic [PW:0]   ptr_cnt;
  logic          last_byte;
  logic [7:0]    rd_first;
  logic [7:0]    rd_next;

  assign ptr_inc   = ptr_q + PW'(1);
  assign ptr_cnt   = {1'b0, ptr_q} + (PW+1)'(1);
  assign last_byte = (ptr_cnt == XFER_W);
  assign rd_first  = mem_q[0];
  assign rd_next   = mem_q[ptr_inc];

  // Next-state logic: each shift pulse is phase A (nSHIFT low, move a bit) then phase B (nSHIFT high, count).
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    cmd_last_d = cmd_last_q;
    dat_d      = dat_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    phase_d    = phase_q;
    nshift_d   = nshift_q;
    nout_d     = nout_q;
    ndi_d      = ndi_q;
    nerr_d     = nerr_q;
    ndone_d    = ndone_q;
    ntr_d      = ntr_q;
    mem_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        ndone_d = 1'b0;
        if (!PIN_nRUN) begin
          ndone_d = 1'b1;
          cmd_d   = {8'b0, ~PIN_nDO};
          cnt_d   = 4'd8;
          phase_d = 1'b0;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (!phase_q) begin
          nshift_d = 1'b0;
          cmd_d    = {cmd_q[7:0], ~PIN_nDO};
          phase_d  = 1'b1;
        end else begin
          nshift_d = 1'b1;
          phase_d  = 1'b0;
          cnt_d    = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            cmd_last_d = cmd_q;
            state_d    = S_DEC;
          end
        end
      end
      S_DEC: begin
        case (cmd_q[4:1])
          4'b0000: begin
            ntr_d   = 1'b0;
            nerr_d  = 1'b1;
            ptr_d   = '0;
            state_d = S_FWAIT;
          end
          4'b0001: begin
            nout_d  = 1'b0;
            nerr_d  = 1'b1;
            dat_d   = rd_first;
            ndi_d   = ~rd_first[7];
            cnt_d   = 4'd7;
            phase_d = 1'b0;
            ptr_d   = '0;
            state_d = S_ESHIFT;
          end
          default: begin
            ndone_d = 1'b0;
            nerr_d  = 1'b0;
            state_d = S_IDLE;
          end
        endcase
      end
      S_FWAIT: begin
        if (!PIN_nRUN) begin
          ntr_d   = 1'b1;
          dat_d   = {7'b0, ~PIN_nDO};
          cnt_d   = 4'd8;
          phase_d = 1'b0;
          state_d = S_FSHIFT;
        end
      end
      S_FSHIFT: begin
        if (!phase_q) begin
          nshift_d = 1'b0;
          dat_d    = {dat_q[6:0], ~PIN_nDO};
          phase_d  = 1'b1;
        end else begin
          nshift_d = 1'b1;
          phase_d  = 1'b0;
          cnt_d    = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            mem_we = 1'b1;
            ptr_d  = ptr_inc;
            if (last_byte) begin
              ndone_d = 1'b0;
              nerr_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              ntr_d   = 1'b0;
              state_d = S_FWAIT;
            end
          end
        end
      end
      S_ESHIFT: begin
        if (!phase_q) begin
          nshift_d = 1'b0;
          dat_d    = {dat_q[6:0], 1'b0};
          ndi_d    = ~dat_q[6];
          phase_d  = 1'b1;
        end else begin
          nshift_d = 1'b1;
          phase_d  = 1'b0;
          cnt_d    = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            ntr_d   = 1'b0;
            state_d = S_EWAIT;
          end
        end
      end
      S_EWAIT: begin
        if (!PIN_nRUN) begin
          ntr_d = 1'b1;
          ptr_d = ptr_inc;
          if (last_byte) begin
            nout_d  = 1'b1;
            ndone_d = 1'b0;
            nerr_d  = 1'b1;
            ndi_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            dat_d   = rd_next;
            ndi_d   = ~rd_next[7];
            cnt_d   = 4'd7;
            phase_d = 1'b0;
            state_d = S_ESHIFT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset and nSET override everything, nSET keeps the last command word.
  always_ff @(posedge PIN_CLK) begin
    if (!PIN_nRST || !PIN_nSET) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      dat_q    <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      phase_q  <= 1'b0;
      nshift_q <= 1'b1;
      nout_q   <= 1'b1;
      ndi_q    <= 1'b1;
      nerr_q   <= 1'b1;
      ndone_q  <= 1'b1;
      ntr_q    <= 1'b1;
      if (!PIN_nRST) cmd_last_q <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      cmd_last_q <= cmd_last_d;
      dat_q      <= dat_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      phase_q    <= phase_d;
      nshift_q   <= nshift_d;
      nout_q     <= nout_d;
      ndi_q      <= ndi_d;
      nerr_q     <= nerr_d;
      ndone_q    <= ndone_d;
      ntr_q      <= ntr_d;
    end
  end

  // Sector buffer write; contents survive reset and nSET, and an aborting cycle never writes.
  always_ff @(posedge PIN_CLK) begin
    if (mem_we && PIN_nRST && PIN_nSET) mem_q[ptr_q] <= dat_q;
  end

  assign PIN_nSHIFT = nshift_q;
  assign PIN_nOUT   = nout_q;
  assign PIN_nDI    = ndi_q;
  assign PIN_nERR   = nerr_q;
  assign PIN_nDONE  = ndone_q;
  assign PIN_nTR    = ntr_q;
  assign CMD_LAST   = cmd_last_q;

endmodule
